// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences MEM-stage loads/stores onto a word-wide data memory with a request/ack handshake.
// Optional misalignment trap (adds MISALIGNED output) enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT,
    output logic        ACCESS_ERR,
    output logic        DM_READ,
    output logic        DM_WRITE,
    output logic [29:0] DM_ADDRESS,
    output logic [31:0] DM_WRITEDATA,
    output logic [3:0]  DM_BYTEEN,
    input  logic [31:0] DM_READDATA,
    input  logic        DM_ACK
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic        MISALIGNED
`endif
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d, wd_q, wd_d, rdata_q, rdata_d, ld_word;
    logic [2:0]  f3_q, f3_d;
    logic        dmr_q, dmr_d, dmw_q, dmw_d, err_q, err_d, busy;
    logic        one_op, legal, misal, reject, timeout;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [3:0]  be;
    assign one_op = MEM_READ ^ MEM_WRITE;
    assign legal  = MEM_READ ? (FUNCT3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                             : (FUNCT3 inside {3'b000, 3'b001, 3'b010});
`ifdef DMEM_MISALIGN_TRAP_EN
    logic mis_q, mis_d;
    assign misal = (FUNCT3[1:0] == 2'b01 && ADDRESS[0]) || (FUNCT3[1:0] == 2'b10 && ADDRESS[1:0] != 2'b00);
    assign MISALIGNED = mis_q;
`else
    assign misal = 1'b0;
`endif
    assign reject  = !one_op || !legal || misal;
    // A zero limit disables the timeout entirely.
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign ld_byte = addr_q[1] ? (addr_q[0] ? DM_READDATA[31:24] : DM_READDATA[23:16])
                               : (addr_q[0] ? DM_READDATA[15:8]  : DM_READDATA[7:0]);
    assign ld_half = addr_q[1] ? DM_READDATA[31:16] : DM_READDATA[15:0];
    assign ld_word = f3_q[1] ? DM_READDATA
                   : f3_q[0] ? {{16{~f3_q[2] & ld_half[15]}}, ld_half}
                   : {{24{~f3_q[2] & ld_byte[7]}}, ld_byte};
    assign be = f3_q[1] ? 4'b1111 : f3_q[0] ? (4'b0011 << {addr_q[1], 1'b0}) : (4'b0001 << addr_q[1:0]);
    assign DM_BYTEEN    = (dmr_q | dmw_q) ? be : 4'b0000;
    assign DM_WRITEDATA = f3_q[1] ? wd_q : f3_q[0] ? {2{wd_q[15:0]}} : {4{wd_q[7:0]}};
    assign DM_ADDRESS   = addr_q[31:2];
    assign DM_READ      = dmr_q;
    assign DM_WRITE     = dmw_q;
    assign READ_DATA    = rdata_q;
    assign ACCESS_ERR   = err_q;
    assign BUSYWAIT     = RESET & busy;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        wd_d    = wd_q;
        dmr_d   = 1'b0;
        dmw_d   = 1'b0;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        busy    = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        mis_d   = 1'b0;
`endif
        case (state_q)
            IDLE: if (MEM_READ || MEM_WRITE) begin
                busy = 1'b1;
                if (reject) begin
                    state_d = DONE;
                    err_d   = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
                    mis_d   = one_op & legal & misal;
`endif
                end else begin
                    state_d = REQ;
                    cnt_d   = '0;
                    addr_d  = ADDRESS;
                    f3_d    = FUNCT3;
                    wd_d    = WRITE_DATA;
                    dmr_d   = MEM_READ;
                    dmw_d   = MEM_WRITE;
                end
            end
            REQ: begin
                busy  = 1'b1;
                dmr_d = dmr_q;
                dmw_d = dmw_q;
                if (DM_ACK || timeout) begin
                    state_d = DONE;
                    dmr_d   = 1'b0;
                    dmw_d   = 1'b0;
                    err_d   = !DM_ACK;
                    rdata_d = dmr_q ? (DM_ACK ? ld_word : 32'h0) : rdata_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            f3_q    <= '0;
            wd_q    <= '0;
            dmr_q   <= 1'b0;
            dmw_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            wd_q    <= wd_d;
            dmr_q   <= dmr_d;
            dmw_q   <= dmw_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef DMEM_MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
        end
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: randomized and directed checks of dmem_access_ctrl against a behavioural model.
module tb_dmem_access_ctrl;
    logic        CLK = 1'b0, RESET = 1'b0, MEM_READ = 1'b0, MEM_WRITE = 1'b0, DM_ACK = 1'b0;
    logic [2:0]  FUNCT3 = '0;
    logic [31:0] ADDRESS = '0, WRITE_DATA = '0, DM_READDATA = '0;
    logic [31:0] READ_DATA, DM_WRITEDATA;
    logic        BUSYWAIT, ACCESS_ERR, DM_READ, DM_WRITE;
    logic [29:0] DM_ADDRESS;
    logic [3:0]  DM_BYTEEN;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        MISALIGNED;
`endif
    int checks = 0, failures = 0;
    int o_busy, o_req, o_err, o_mis;
    bit o_hang, o_stable, o_dmr, o_dmw;
    logic [29:0] o_addr;
    logic [3:0]  o_be;
    logic [31:0] o_wd, o_rd, exp_rd;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .FUNCT3(FUNCT3),
        .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA), .READ_DATA(READ_DATA), .BUSYWAIT(BUSYWAIT),
        .ACCESS_ERR(ACCESS_ERR), .DM_READ(DM_READ), .DM_WRITE(DM_WRITE), .DM_ADDRESS(DM_ADDRESS),
        .DM_WRITEDATA(DM_WRITEDATA), .DM_BYTEEN(DM_BYTEEN), .DM_READDATA(DM_READDATA), .DM_ACK(DM_ACK)
`ifdef DMEM_MISALIGN_TRAP_EN
        , .MISALIGNED(MISALIGNED)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic int m_size(logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic int m_off(logic [2:0] f3, logic [31:0] a);
        return (int'(a % 4) / m_size(f3)) * m_size(f3);
    endfunction

    function automatic logic [31:0] m_load(logic [31:0] w, logic [2:0] f3, logic [31:0] a);
        logic [31:0] v;
        v = w >> (8 * m_off(f3, a));
        if (m_size(f3) == 1) v = (!f3[2] && v[7]) ? (v & 32'hFF) | 32'hFFFFFF00 : v & 32'hFF;
        if (m_size(f3) == 2) v = (!f3[2] && v[15]) ? (v & 32'hFFFF) | 32'hFFFF0000 : v & 32'hFFFF;
        return v;
    endfunction

    function automatic logic [3:0] m_be(logic [2:0] f3, logic [31:0] a);
        return 4'(((1 << m_size(f3)) - 1) << m_off(f3, a));
    endfunction

    function automatic logic [31:0] m_wd(logic [2:0] f3, logic [31:0] wd);
        return m_size(f3) == 1 ? (wd & 32'hFF) * 32'h01010101 : m_size(f3) == 2 ? (wd & 32'hFFFF) * 32'h00010001 : wd;
    endfunction

    function automatic bit m_legal(bit rd, logic [2:0] f3);
        return rd ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) : (f3 <= 2);
    endfunction

    function automatic bit m_mis(logic [2:0] f3, logic [31:0] a);
`ifdef DMEM_MISALIGN_TRAP_EN
        return (a % m_size(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Drives one instruction until its DONE cycle and records what the memory side saw.
    task automatic run(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] word, input int ack_at, input bit noise);
        @(negedge CLK);
        MEM_READ = rd; MEM_WRITE = wr; FUNCT3 = f3; ADDRESS = a; WRITE_DATA = wd; DM_READDATA = word; DM_ACK = 1'b0;
        o_busy = 0; o_req = 0; o_err = 0; o_mis = 0; o_hang = 1; o_stable = 1; o_dmr = 0; o_dmw = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (BUSYWAIT) o_busy++;
            if (ACCESS_ERR) o_err++;
`ifdef DMEM_MISALIGN_TRAP_EN
            if (MISALIGNED) o_mis++;
`endif
            if (c > 0 && !BUSYWAIT) begin
                o_rd = READ_DATA;
                o_hang = 0;
                break;
            end
            if (DM_READ || DM_WRITE) begin
                if (o_req == 0) begin
                    o_dmr = DM_READ; o_dmw = DM_WRITE; o_addr = DM_ADDRESS; o_be = DM_BYTEEN; o_wd = DM_WRITEDATA;
                end else if (DM_READ !== o_dmr || DM_WRITE !== o_dmw || DM_ADDRESS !== o_addr ||
                             DM_BYTEEN !== o_be || DM_WRITEDATA !== o_wd) o_stable = 0;
                o_req++;
                DM_ACK = (ack_at != 0 && o_req == ack_at);
            end else DM_ACK = noise ? 1'($urandom % 2) : 1'b0;
            @(negedge CLK);
        end
        MEM_READ = 1'b0; MEM_WRITE = 1'b0; DM_ACK = 1'b0;
        @(negedge CLK);
        #1;
        if (ACCESS_ERR) o_err++;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (MISALIGNED) o_mis++;
`endif
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        checks++; if (READ_DATA !== 32'h0) begin failures++; $display("FAIL reset_read_data got=%h exp=0", READ_DATA); end
        checks++; if (BUSYWAIT !== 1'b0) begin failures++; $display("FAIL reset_busywait got=%b exp=0", BUSYWAIT); end
        checks++; if (ACCESS_ERR !== 1'b0) begin failures++; $display("FAIL reset_access_err got=%b exp=0", ACCESS_ERR); end
        checks++; if ({DM_READ, DM_WRITE} !== 2'b00) begin failures++; $display("FAIL reset_dm_rw got=%b exp=00", {DM_READ, DM_WRITE}); end
        checks++; if (DM_ADDRESS !== 30'h0) begin failures++; $display("FAIL reset_dm_address got=%h exp=0", DM_ADDRESS); end
        checks++; if (DM_BYTEEN !== 4'h0) begin failures++; $display("FAIL reset_dm_byteen got=%b exp=0000", DM_BYTEEN); end
        checks++; if (DM_WRITEDATA !== 32'h0) begin failures++; $display("FAIL reset_dm_writedata got=%h exp=0", DM_WRITEDATA); end
`ifdef DMEM_MISALIGN_TRAP_EN
        checks++; if (MISALIGNED !== 1'b0) begin failures++; $display("FAIL reset_misaligned got=%b exp=0", MISALIGNED); end
`endif
        RESET = 1'b1;
        exp_rd = 32'h0;
    endtask

    task automatic test_spec_vectors();
        run(1, 0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1, 0);
        checks++; if (o_busy != 2) begin failures++; $display("FAIL lb_busy_cycles got=%0d exp=2", o_busy); end
        checks++; if (o_rd !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_read_data got=%h exp=ffffff80", o_rd); end
        run(0, 1, 3'b001, 32'h42, 32'h1234ABCD, 32'h0, 1, 0);
        checks++; if (o_dmw !== 1'b1 || o_dmr !== 1'b0) begin failures++; $display("FAIL sh_dm_rw got=%b%b exp=01", o_dmr, o_dmw); end
        checks++; if (o_addr !== 30'h10) begin failures++; $display("FAIL sh_dm_address got=%h exp=10", o_addr); end
        checks++; if (o_be !== 4'b1100) begin failures++; $display("FAIL sh_dm_byteen got=%b exp=1100", o_be); end
        checks++; if (o_wd !== 32'hABCDABCD) begin failures++; $display("FAIL sh_dm_writedata got=%h exp=abcdabcd", o_wd); end
        checks++; if (o_rd !== 32'hFFFFFF80) begin failures++; $display("FAIL sh_read_data_held got=%h exp=ffffff80", o_rd); end
        run(1, 0, 3'b101, 32'h2, 32'h0, 32'hBEEF0000, 3, 0);
        checks++; if (o_busy != 4) begin failures++; $display("FAIL lhu_busy_cycles got=%0d exp=4", o_busy); end
        checks++; if (o_rd !== 32'h0000BEEF) begin failures++; $display("FAIL lhu_read_data got=%h exp=0000beef", o_rd); end
        checks++; if (!o_stable) begin failures++; $display("FAIL lhu_req_stable got=0 exp=1"); end
        run(1, 0, 3'b010, 32'h0, 32'h0, 32'hDEADBEEF, 0, 0);
        checks++; if (o_req != 4) begin failures++; $display("FAIL timeout_req_cycles got=%0d exp=4", o_req); end
        checks++; if (o_err != 1) begin failures++; $display("FAIL timeout_err_pulse got=%0d exp=1", o_err); end
        checks++; if (o_rd !== 32'h0) begin failures++; $display("FAIL timeout_read_data got=%h exp=0", o_rd); end
        run(1, 0, 3'b010, 32'h6, 32'h0, 32'h55AA55AA, 1, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        checks++; if (o_req != 0) begin failures++; $display("FAIL lw_mis_no_access got=%0d exp=0", o_req); end
        checks++; if (o_mis != 1 || o_err != 1) begin failures++; $display("FAIL lw_mis_pulses got=%0d/%0d exp=1/1", o_mis, o_err); end
        checks++; if (o_rd !== 32'h0) begin failures++; $display("FAIL lw_mis_read_data got=%h exp=0", o_rd); end
        exp_rd = 32'h0;
`else
        checks++; if (o_addr !== 30'h1 || o_dmr !== 1'b1) begin failures++; $display("FAIL lw_a6_request got=%h/%b exp=1/1", o_addr, o_dmr); end
        checks++; if (o_rd !== 32'h55AA55AA || o_err != 0) begin failures++; $display("FAIL lw_a6_read got=%h/%0d exp=55aa55aa/0", o_rd, o_err); end
        exp_rd = 32'h55AA55AA;
`endif
    endtask

    task automatic test_illegal();
        run(1, 1, 3'b010, 32'h40, 32'h0, 32'h11111111, 1, 0);
        checks++; if (o_req != 0 || o_busy != 1) begin failures++; $display("FAIL both_ops_access got=%0d/%0d exp=0/1", o_req, o_busy); end
        checks++; if (o_err != 1) begin failures++; $display("FAIL both_ops_err got=%0d exp=1", o_err); end
        run(0, 1, 3'b100, 32'h40, 32'h0, 32'h11111111, 1, 0);
        checks++; if (o_req != 0 || o_err != 1) begin failures++; $display("FAIL bad_store_f3 got=%0d/%0d exp=0/1", o_req, o_err); end
        run(1, 0, 3'b011, 32'h40, 32'h0, 32'h11111111, 1, 0);
        checks++; if (o_req != 0 || o_err != 1 || o_rd !== exp_rd) begin failures++; $display("FAIL bad_load_f3 got=%0d/%0d/%h exp=0/1/%h", o_req, o_err, o_rd, exp_rd); end
    endtask

    task automatic test_random();
        logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int n = 0; n < 80; n++) begin
            int op = $urandom % 8, ack_at = $urandom % 5;
            bit rd = (op < 3) || op == 6, wr = (op >= 3);
            logic [2:0] f3;
            logic [31:0] a = $urandom, wd = $urandom, word = $urandom;
            bit bad;
            f3 = ($urandom % 5 == 0) ? 3'($urandom % 8) : rd ? ld_f3[$urandom % 5] : 3'($urandom % 3);
            bad = (rd && wr) || !m_legal(rd, f3) || m_mis(f3, a);
            run(rd, wr, f3, a, wd, word, ack_at, 1);
            checks++; if (o_hang) begin failures++; $display("FAIL rnd_done_seen n=%0d got=none exp=done", n); end
            if (bad) begin
                checks++; if (o_req != 0 || o_busy != 1 || o_err != 1) begin failures++; $display("FAIL rnd_reject n=%0d got=req%0d busy%0d err%0d exp=0/1/1", n, o_req, o_busy, o_err); end
`ifdef DMEM_MISALIGN_TRAP_EN
                checks++; if (o_mis != int'(m_mis(f3, a) && !(rd && wr) && m_legal(rd, f3))) begin failures++; $display("FAIL rnd_misaligned n=%0d got=%0d", n, o_mis); end
`endif
            end else begin
                int exp_req = ack_at != 0 ? ack_at : 4;
                if (rd) exp_rd = ack_at != 0 ? m_load(word, f3, a) : 32'h0;
                checks++; if (o_req != exp_req || o_busy != exp_req + 1) begin failures++; $display("FAIL rnd_latency n=%0d got=req%0d busy%0d exp=%0d", n, o_req, o_busy, exp_req); end
                checks++; if (o_err != int'(ack_at == 0)) begin failures++; $display("FAIL rnd_err n=%0d got=%0d exp=%0d", n, o_err, ack_at == 0); end
                checks++; if (o_dmr !== rd || o_dmw !== wr || o_addr !== a[31:2] || !o_stable) begin failures++; $display("FAIL rnd_request n=%0d got=%b%b %h stable%0d exp=%b%b %h", n, o_dmr, o_dmw, o_addr, o_stable, rd, wr, a[31:2]); end
                if (wr) begin
                    checks++; if (o_be !== m_be(f3, a) || o_wd !== m_wd(f3, wd)) begin failures++; $display("FAIL rnd_store n=%0d got=%b %h exp=%b %h", n, o_be, o_wd, m_be(f3, a), m_wd(f3, wd)); end
                end
            end
            checks++; if (o_rd !== exp_rd) begin failures++; $display("FAIL rnd_read_data n=%0d f3=%0d a=%h got=%h exp=%h", n, f3, a, o_rd, exp_rd); end
        end
    endtask

    task automatic test_reset_in_req();
        run(1, 0, 3'b010, 32'h20, 32'h0, 32'h12345678, 2, 0);
        checks++; if (o_rd !== 32'h12345678) begin failures++; $display("FAIL pre_reset_load got=%h exp=12345678", o_rd); end
        @(negedge CLK);
        MEM_READ = 1'b1; FUNCT3 = 3'b010; ADDRESS = 32'h24; DM_ACK = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        checks++; if (DM_READ !== 1'b1) begin failures++; $display("FAIL in_req_dm_read got=%b exp=1", DM_READ); end
        RESET = 1'b0;
        @(negedge CLK);
        #1;
        checks++; if (DM_READ !== 1'b0 || BUSYWAIT !== 1'b0) begin failures++; $display("FAIL rst_req_idle got=%b%b exp=00", DM_READ, BUSYWAIT); end
        checks++; if (READ_DATA !== 32'h0) begin failures++; $display("FAIL rst_req_read_data got=%h exp=0", READ_DATA); end
        RESET = 1'b1; MEM_READ = 1'b0; DM_ACK = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        checks++; if (BUSYWAIT !== 1'b0 || DM_READ !== 1'b0 || ACCESS_ERR !== 1'b0 || READ_DATA !== 32'h0) begin
            failures++; $display("FAIL late_ack_ignored got=busy%b rd%b err%b data%h exp=0/0/0/0", BUSYWAIT, DM_READ, ACCESS_ERR, READ_DATA);
        end
        DM_ACK = 1'b0;
        exp_rd = 32'h0;
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_illegal();
        test_random();
        test_reset_in_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
